move_frame_plotter: RTL and testbench

- Receiver end of the serialized move stream: one word (x, y, color) per cycle, in the order paddle1, paddle2, ball, with ld high on the ball word.
- Rebuilds the three object positions into a frame.
- Redraws the frame pixel by pixel into the VGA adapter write port: erase the old frame, then draw the new one.
- Sits between the move serializer and the VGA adapter.

---
 rtl/move_frame_plotter.sv | 157 +++++++++++++++
 tb/tb_move_frame_plotter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_frame_plotter.sv
// Rebuilds (p1, p2, ball) frames from the serialized move stream and redraws them into the VGA write port.
// Optional build macro FRAME_DROP_CNT_EN adds drop_cnt, a saturating count of overwritten pending frames.
module move_frame_plotter #(
    parameter int         PADDLE_W = 2,
    parameter int         PADDLE_H = 16,
    parameter int         BALL_SZ  = 2,
    parameter logic [2:0] BG_COLOR = 3'b000,
    parameter int         X_MAX    = 159,
    parameter int         Y_MAX    = 119
) (
    input  logic       clk,
    input  logic       reset_co,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] color_in,
    input  logic       ld,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] plot_color,
    output logic       plot,
    output logic       busy,
    output logic       frame_done
`ifdef FRAME_DROP_CNT_EN
   ,output logic [7:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    localparam logic [7:0] PW_M1 = 8'(PADDLE_W - 1);
    localparam logic [6:0] PH_M1 = 7'(PADDLE_H - 1);
    localparam logic [7:0] BW_M1 = 8'(BALL_SZ - 1);
    localparam logic [6:0] BH_M1 = 7'(BALL_SZ - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Each object record is {x[7:0], y[6:0], color[2:0]}; frame holds p1 in the low slot, ball in the high slot.
    state_t      state;
    logic [17:0] word, h0, h1, rec;
    logic [53:0] new_frame, take, src, cur, old, pend;
    logic        old_valid, pend_valid;
    logic [1:0]  obj;
    logic [7:0]  dx, w_m1;
    logic [6:0]  dy, h_m1;
    logic [8:0]  px;
    logic [7:0]  py;
    logic        in_view, obj_end;

    assign word      = {x_in, y_in, color_in};
    assign new_frame = {word, h0, h1};
    assign busy      = (state != IDLE);

    always_comb begin
        take = ld ? new_frame : pend;
        src  = (state == ERASE) ? old : cur;
        case (obj)
            2'd0:    rec = src[17:0];
            2'd1:    rec = src[35:18];
            default: rec = src[53:36];
        endcase
        w_m1    = (obj == 2'd2) ? BW_M1 : PW_M1;
        h_m1    = (obj == 2'd2) ? BH_M1 : PH_M1;
        px      = {1'b0, rec[17:10]} + {1'b0, dx};
        py      = {1'b0, rec[9:3]} + {1'b0, dy};
        in_view = (px <= 9'(X_MAX)) && (py <= 8'(Y_MAX));
        obj_end = (dx == w_m1) && (dy == h_m1);
    end

    always_ff @(posedge clk or negedge reset_co) begin
        if (!reset_co) begin
            state      <= IDLE;
            h0         <= '0;
            h1         <= '0;
            cur        <= '0;
            old        <= '0;
            pend       <= '0;
            old_valid  <= 1'b0;
            pend_valid <= 1'b0;
            obj        <= '0;
            dx         <= '0;
            dy         <= '0;
            plot       <= 1'b0;
            plot_x     <= '0;
            plot_y     <= '0;
            plot_color <= '0;
            frame_done <= 1'b0;
        end else begin
            plot       <= 1'b0;
            frame_done <= 1'b0;
            if (!ld) begin
                h1 <= h0;
                h0 <= word;
            end
            // A frame arriving mid-redraw parks in pend; the running walk is untouched.
            if (ld && state != IDLE) begin
                pend       <= new_frame;
                pend_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ld || pend_valid) begin
                        if (!ld)
                            pend_valid <= 1'b0;
                        if (!(old_valid && take == old)) begin
                            cur   <= take;
                            obj   <= '0;
                            dx    <= '0;
                            dy    <= '0;
                            state <= old_valid ? ERASE : DRAW;
                        end
                    end
                end
                ERASE, DRAW: begin
                    plot       <= in_view;
                    plot_x     <= px[7:0];
                    plot_y     <= py[6:0];
                    plot_color <= (state == ERASE) ? BG_COLOR : rec[2:0];
                    // dx is the inner loop, dy the outer, objects in p1, p2, ball order.
                    if (dx != w_m1) begin
                        dx <= dx + 8'd1;
                    end else begin
                        dx <= '0;
                        if (!obj_end) begin
                            dy <= dy + 7'd1;
                        end else begin
                            dy <= '0;
                            if (obj != 2'd2) begin
                                obj <= obj + 2'd1;
                            end else begin
                                obj   <= '0;
                                state <= (state == ERASE) ? DRAW : DONE;
                            end
                        end
                    end
                end
                default: begin
                    old        <= cur;
                    old_valid  <= 1'b1;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset_co) begin
        if (!reset_co)
            drop_cnt <= '0;
        else if (ld && state != IDLE && pend_valid)
            drop_cnt <= sat_inc(drop_cnt);
    end
`endif

endmodule

// File: tb/tb_move_frame_plotter.sv
// Scoreboard bench for move_frame_plotter: stimulus queues expected pixels/frame_done, a monitor pops and compares.
module tb_move_frame_plotter;

    typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} obj_t;
    typedef struct packed {obj_t b; obj_t p2; obj_t p1;} frame_t;
    typedef struct packed {logic done; logic [31:0] cyc; logic [7:0] x; logic [6:0] y; logic [2:0] c;} ev_t;

    logic       clk = 1'b0;
    logic       reset_co = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [2:0] color_in = '0;
    logic       ld = 1'b0;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_color;
    logic       plot, busy, frame_done;
`ifdef FRAME_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    move_frame_plotter dut (
        .clk(clk), .reset_co(reset_co), .x_in(x_in), .y_in(y_in), .color_in(color_in), .ld(ld),
        .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color), .plot(plot), .busy(busy),
        .frame_done(frame_done)
`ifdef FRAME_DROP_CNT_EN
       ,.drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    ev_t  sb[$];
    ev_t  exp_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic obj_t ob(input int x, input int y, input int c);
        obj_t o;
        o.x = x[7:0];
        o.y = y[6:0];
        o.c = c[2:0];
        return o;
    endfunction

    function automatic frame_t fr(input obj_t a, input obj_t b, input obj_t c);
        frame_t f;
        f.p1 = a;
        f.p2 = b;
        f.b  = c;
        return f;
    endfunction

    function automatic obj_t pick(input frame_t f, input int i);
        case (i)
            0:       return f.p1;
            1:       return f.p2;
            default: return f.b;
        endcase
    endfunction

    // Expected output of one redraw whose frame was accepted at edge L.
    task automatic push_walk(input int L, input frame_t f, input bit erase, input frame_t o);
        int   k = 0;
        ev_t  e;
        obj_t r;
        int   w, h, px, py;
        for (int pass = (erase ? 0 : 1); pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                r = pick((pass == 0) ? o : f, i);
                w = (i < 2) ? 2 : 2;
                h = (i < 2) ? 16 : 2;
                for (int dy = 0; dy < h; dy++) begin
                    for (int dx = 0; dx < w; dx++) begin
                        px = int'(r.x) + dx;
                        py = int'(r.y) + dy;
                        if (px <= 159 && py <= 119) begin
                            e.done = 1'b0;
                            e.cyc  = L + 1 + k;
                            e.x    = px[7:0];
                            e.y    = py[6:0];
                            e.c    = (pass == 0) ? 3'd0 : r.c;
                            sb.push_back(e);
                        end
                        k++;
                    end
                end
            end
        end
        e = '0;
        e.done = 1'b1;
        e.cyc  = L + 1 + k;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_co && (plot || frame_done)) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected output cyc=%0d plot=%0b done=%0b x=%0d y=%0d c=%0d",
                         cyc, plot, frame_done, plot_x, plot_y, plot_color);
            end else begin
                exp_e = sb.pop_front();
                if (exp_e.done != frame_done || exp_e.cyc != cyc ||
                    (!frame_done && (exp_e.x != plot_x || exp_e.y != plot_y || exp_e.c != plot_color))) begin
                    n_bad++;
                    $display("FAIL pixel: got cyc=%0d done=%0b x=%0d y=%0d c=%0d, expected cyc=%0d done=%0b x=%0d y=%0d c=%0d",
                             cyc, frame_done, plot_x, plot_y, plot_color,
                             exp_e.cyc, exp_e.done, exp_e.x, exp_e.y, exp_e.c);
                end
            end
        end
    end

    task automatic drive(input obj_t o, input logic l);
        x_in = o.x;
        y_in = o.y;
        color_in = o.c;
        ld = l;
    endtask

    task automatic send(input frame_t f, output int L);
        drive(f.p1, 1'b0);
        @(negedge clk);
        drive(f.p2, 1'b0);
        @(negedge clk);
        drive(f.b, 1'b1);
        L = cyc + 1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("redraw finished in budget", int'(busy), 0);
    endtask

    frame_t f1, f2, f3, fa, fb, fe, fg;
    int     L, La;

    initial begin
        f1 = fr(ob(10, 20, 1), ob(140, 20, 2), ob(80, 60, 7));
        f2 = fr(ob(10, 22, 1), ob(140, 20, 2), ob(80, 60, 7));
        f3 = fr(ob(10, 22, 1), ob(140, 20, 2), ob(159, 119, 7));
        fa = fr(ob(0, 0, 3), ob(158, 104, 4), ob(20, 30, 5));
        fe = fr(ob(5, 5, 2), ob(150, 50, 3), ob(60, 60, 4));
        fg = fr(ob(1, 2, 3), ob(120, 100, 4), ob(70, 110, 5));
        fb = fa;

        repeat (3) @(negedge clk);
        chk("reset plot", int'(plot), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset plot_x", int'(plot_x), 0);
        chk("reset plot_y", int'(plot_y), 0);
        chk("reset plot_color", int'(plot_color), 0);
`ifdef FRAME_DROP_CNT_EN
        chk("reset drop_cnt", int'(drop_cnt), 0);
`endif
        reset_co = 1'b1;
        @(negedge clk);

        // First frame: draw only.
        send(f1, L);
        push_walk(L, f1, 1'b0, f1);
        chk("busy after first ld", int'(busy), 1);
        wait_idle(200);

        // p1 moved: erase then draw.
        send(f2, L);
        push_walk(L, f2, 1'b1, f1);
        wait_idle(300);

        // Identical frame is discarded.
        send(f2, L);
        for (int i = 0; i < 6; i++) begin
            chk("busy on identical frame", int'(busy), 0);
            @(negedge clk);
        end

        // Ball in the corner: three of its four pixels clipped.
        send(f3, L);
        push_walk(L, f3, 1'b1, f2);
        wait_idle(300);

        // Burst of frames every 4 cycles while busy; only the last is drawn next.
        send(fa, La);
        push_walk(La, fa, 1'b1, f3);
        for (int i = 0; i < 10; i++) begin
            fb = fr(ob(30 + i, 40, 1), ob(100, 10 + i, 2), ob(50 + i, 70, 6));
            send(fb, L);
            @(negedge clk);
        end
        push_walk(La + 138, fb, 1'b1, fa);
`ifdef FRAME_DROP_CNT_EN
        chk("drop_cnt after burst", int'(drop_cnt), 9);
`endif
        while (cyc < La + 140) @(negedge clk);
        chk("busy on pending redraw", int'(busy), 1);
        wait_idle(300);

        // Reset in the middle of an erase pass.
        send(fe, L);
        push_walk(L, fe, 1'b1, fb);
        repeat (10) @(negedge clk);
        #2 reset_co = 1'b0;
        #1;
        chk("plot on mid-erase reset", int'(plot), 0);
        chk("busy on mid-erase reset", int'(busy), 0);
`ifdef FRAME_DROP_CNT_EN
        chk("drop_cnt on mid-erase reset", int'(drop_cnt), 0);
`endif
        sb.delete();
        @(negedge clk);
        reset_co = 1'b1;
        @(negedge clk);

        // Next frame after reset is drawn without erase.
        send(fg, L);
        push_walk(L, fg, 1'b0, fg);
        chk("busy after post-reset ld", int'(busy), 1);
        wait_idle(200);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
